// File: rtl/conv_window_ctrl.sv
// Window sequencer for the KSIZE x KSIZE line-buffer chain: accepts raster pixels, drives row-buffer shift,
// flags complete windows. Optional build macro CONV_WIN_STRIDE2_EN adds the stride-2 qualification input.
module conv_window_ctrl #(
  parameter int KSIZE = 3,
  parameter int MAX_W = 320,
  parameter int MAX_H = 240,
  localparam int CW = $clog2(MAX_W),
  localparam int RW = $clog2(MAX_H)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_start,
  input  logic [CW-1:0] i_cfg_w,
  input  logic [RW-1:0] i_cfg_h,
`ifdef CONV_WIN_STRIDE2_EN
  input  logic          i_stride2,
`endif
  input  logic          i_s_valid,
  output logic          o_s_ready,
  output logic          o_buf_shift,
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic [CW-1:0] o_win_col,
  output logic [RW-1:0] o_win_row,
  output logic          o_win_last,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_w_m1;
  logic [RW-1:0] r_h_m1;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_last_col;
  logic [RW-1:0] r_last_row;
  logic          r_m_valid;
  logic [CW-1:0] r_win_col;
  logic [RW-1:0] r_win_row;
  logic          r_win_last;
  logic          r_done;
  logic          r_cfg_err;
`ifdef CONV_WIN_STRIDE2_EN
  logic          r_stride2;
`endif

  logic          w_cfg_ok;
  logic          w_accept;
  logic          w_qualify;
  logic          w_end_pixel;
  logic [CW-1:0] w_cfg_last_col;
  logic [RW-1:0] w_cfg_last_row;

  // Geometry check done one bit wider so MAX_W/MAX_H never alias when they are powers of two
  assign w_cfg_ok = ({1'b0, i_cfg_w} >= (CW+1)'(KSIZE)) && ({1'b0, i_cfg_w} <= (CW+1)'(MAX_W)) &&
                    ({1'b0, i_cfg_h} >= (RW+1)'(KSIZE)) && ({1'b0, i_cfg_h} <= (RW+1)'(MAX_H));

  assign o_s_ready   = (r_state == S_RUN) && (!r_m_valid || i_m_ready);
  assign w_accept    = i_s_valid && o_s_ready;
  assign o_buf_shift = w_accept;
  assign w_end_pixel = (r_col == r_w_m1) && (r_row == r_h_m1);

`ifdef CONV_WIN_STRIDE2_EN
  // Stride 2 keeps windows whose offset from KSIZE-1 is even; the last one may stop short of the edge
  localparam logic KPAR_POS = 1'((KSIZE - 1) % 2);
  localparam logic KPAR_DIM = 1'(KSIZE % 2);
  assign w_qualify = (r_col >= CW'(KSIZE - 1)) && (r_row >= RW'(KSIZE - 1)) &&
                     (!r_stride2 || ((r_col[0] == KPAR_POS) && (r_row[0] == KPAR_POS)));
  assign w_cfg_last_col = (i_stride2 && (i_cfg_w[0] != KPAR_DIM)) ? (i_cfg_w - CW'(2)) : (i_cfg_w - CW'(1));
  assign w_cfg_last_row = (i_stride2 && (i_cfg_h[0] != KPAR_DIM)) ? (i_cfg_h - RW'(2)) : (i_cfg_h - RW'(1));
`else
  assign w_qualify = (r_col >= CW'(KSIZE - 1)) && (r_row >= RW'(KSIZE - 1));
  assign w_cfg_last_col = i_cfg_w - CW'(1);
  assign w_cfg_last_row = i_cfg_h - RW'(1);
`endif

  assign o_m_valid  = r_m_valid;
  assign o_win_col  = r_win_col;
  assign o_win_row  = r_win_row;
  assign o_win_last = r_win_last;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_cfg_err  = r_cfg_err;

  // Frame FSM, raster counters and registered window outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_w_m1     <= '0;
      r_h_m1     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_last_col <= '0;
      r_last_row <= '0;
      r_m_valid  <= 1'b0;
      r_win_col  <= '0;
      r_win_row  <= '0;
      r_win_last <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
`ifdef CONV_WIN_STRIDE2_EN
      r_stride2  <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_cfg_ok) begin
              r_w_m1     <= i_cfg_w - CW'(1);
              r_h_m1     <= i_cfg_h - RW'(1);
              r_last_col <= w_cfg_last_col;
              r_last_row <= w_cfg_last_row;
              r_col      <= '0;
              r_row      <= '0;
`ifdef CONV_WIN_STRIDE2_EN
              r_stride2  <= i_stride2;
`endif
              r_state    <= S_RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            // Outputs line up with the one-cycle row-buffer read latency
            r_m_valid <= w_qualify;
            if (w_qualify) begin
              r_win_col  <= r_col;
              r_win_row  <= r_row;
              r_win_last <= (r_col == r_last_col) && (r_row == r_last_row);
            end
            if (w_end_pixel) begin
              r_state <= S_DRAIN;
            end else if (r_col == r_w_m1) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end else if (i_m_ready) begin
            r_m_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!r_m_valid || i_m_ready) begin
            r_m_valid <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
